// File: rtl/rom_fetch_if.sv
// Fetch-unit bus bundle: redirect request, synchronous ROM read port,
// ready/valid instruction output stream and sticky fault flag.
interface rom_fetch_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        rom_en;
    logic [8:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    modport master (
        input  redirect, redirect_pc, rom_data, out_ready,
        output rom_en, rom_addr, out_valid, out_instr, out_pc, fault
    );

    modport slave (
        output redirect, redirect_pc, rom_data, out_ready,
        input  rom_en, rom_addr, out_valid, out_instr, out_pc, fault
    );
endinterface

// File: rtl/rom_fetch_unit.sv
// Sequential instruction fetch from a 512-word synchronous ROM into a 2-entry
// FIFO, with redirect flush and a fault stop on out-of-range or misaligned pc.
module rom_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    rom_fetch_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] pending_pc;
    logic        pending;
    logic [1:0]  count;
    logic        rd_ptr, wr_ptr;
    logic [31:0] fifo_instr [2];
    logic [31:0] fifo_pc    [2];
    logic        pc_legal, redirect_legal;
    logic        pop, push, issue;
    logic [2:0]  occupancy;

    function automatic logic is_legal(input logic [31:0] pc);
        return (pc[31:11] == 21'd0) && (pc[1:0] == 2'd0);
    endfunction

    assign pc_legal       = is_legal(fetch_pc);
    assign redirect_legal = is_legal(bus.redirect_pc);

    assign bus.out_valid = (count != 2'd0);
    assign bus.out_instr = bus.out_valid ? fifo_instr[rd_ptr] : '0;
    assign bus.out_pc    = bus.out_valid ? fifo_pc[rd_ptr]    : '0;
    assign pop           = bus.out_valid & bus.out_ready;

    // Count the in-flight read as occupied so the response always has a slot.
    assign occupancy = {1'b0, count} + {2'b0, pending} - {2'b0, pop};
    assign issue     = (state == FETCH) && pc_legal && !bus.redirect
                       && (occupancy < 3'd2);

    assign bus.rom_en   = issue;
    assign bus.rom_addr = fetch_pc[10:2];
    assign push         = pending & ~bus.redirect;
    assign bus.fault    = (state == FAULT) && (count == 2'd0) && !pending;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (!pc_legal) state_nxt = FAULT;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
        // An illegal redirect target faults at once rather than one cycle later.
        if (bus.redirect)
            state_nxt = redirect_legal ? FETCH : FAULT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= '0;
            pending    <= 1'b0;
            count      <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                pending  <= 1'b0;
                count    <= '0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                pending <= issue;
                if (issue) begin
                    fetch_pc   <= fetch_pc + 32'd4;
                    pending_pc <= fetch_pc;
                end
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.rom_data;
            fifo_pc[wr_ptr]    <= pending_pc;
        end
    end
endmodule

// File: doc/rom_fetch_unit.md
ROM_FETCH_UNIT -- requirements
Module: rom_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00000000, byte address of the first instruction fetched after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: redirect  input  1  flush the stream and restart fetching at redirect_pc.
REQ-005 SHALL have port: redirect_pc  input  32  byte address of the new fetch target.
REQ-006 SHALL have port: rom_en  output  1  ROM read enable.
REQ-007 SHALL have port: rom_addr  output  9  ROM word address, equal to fetch_pc[10:2].
REQ-008 SHALL have port: rom_data  input  32  ROM read data, valid in the cycle after the cycle in which rom_en=1.
REQ-009 SHALL have port: out_valid  output  1  out_instr and out_pc hold a valid entry.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the entry.
REQ-011 SHALL have port: out_instr  output  32  instruction word.
REQ-012 SHALL have port: out_pc  output  32  byte address of out_instr.
REQ-013 SHALL have port: fault  output  1  fetch stopped on an illegal pc; sticky until redirect.

Function
REQ-014 SHALL implement states IDLE, FETCH and FAULT; IDLE->FETCH on the first clock edge after reset release.
REQ-015 SHALL treat fetch_pc as legal only when fetch_pc[31:11]==0 and fetch_pc[1:0]==0.
REQ-016 SHALL go FETCH->FAULT when fetch_pc is illegal, and FAULT->FETCH only on redirect with a legal redirect_pc.
REQ-017 SHALL drive rom_en=1 only in FETCH with fetch_pc legal and redirect=0, and only when (count + pending - pop) < 2.
- count: FIFO occupancy.
- pending: rom_en was 1 in the previous cycle.
- pop: out_valid & out_ready.
REQ-018 SHALL advance fetch_pc by 4 in each cycle that rom_en=1; 0x7FC+4=0x800 SHALL lead to FAULT, with no wrap to 0.
REQ-019 SHALL write rom_data, tagged with its pc, into a 2-entry FIFO at the end of the cycle after issue; the write SHALL never overflow.
REQ-020 SHALL present the FIFO head combinationally on out_valid/out_instr/out_pc.
REQ-021 SHALL hold out_instr and out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL pop the head on out_valid & out_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-023 SHALL sustain one instruction per cycle with out_ready held high.
REQ-024 SHALL give latency from rom_en to out_valid of 2 cycles, with no bypass.
REQ-025 SHALL give redirect priority over all other events: in the redirect cycle rom_en=0, and at the next edge it SHALL:
- clear the FIFO;
- drop the pending response;
- load fetch_pc from redirect_pc;
- clear fault.
REQ-026 SHALL allow out_valid=1 during the redirect cycle but SHALL return out_valid=0 in the next cycle.
REQ-027 SHALL, after a legal redirect, raise rom_en in cycle N+1 and out_valid no earlier than cycle N+3, where N is the redirect cycle.
REQ-028 SHALL, in FAULT, still deliver FIFO entries and pending responses issued before the fault.
REQ-029 SHALL assert fault only when in FAULT with the FIFO empty and pending=0.

Reset
REQ-030 SHALL, while rst_n=0, immediately force: state=IDLE, fetch_pc=RESET_PC, count=0, pending=0, rom_en=0, out_valid=0, fault=0, out_instr=0, out_pc=0.
REQ-031 SHALL discard any in-flight ROM response when reset is asserted mid-operation.

Verification
REQ-032 Reset release with RESET_PC=0 and out_ready=1 -> rom_en in cycle 1 with rom_addr=0; out_valid in cycle 3 with out_pc=0; out_pc 0,4,8,... on consecutive cycles.
REQ-033 out_ready=0 for 5 cycles -> 2 entries buffered, rom_en=0 and out_instr stable; on release the pcs arrive in order with no loss or duplicate.
REQ-034 Redirect to 0x404 while the FIFO is full and one read is pending -> the next out_pc is 0x404 with the word at ROM address 0x101; stale words never appear.
REQ-035 Sequential fetch to 0x7FC -> the 0x7FC entry is delivered, then fault=1, out_valid=0 and rom_en=0; a later redirect to 0 clears fault and resumes fetching.
REQ-036 Redirect to 0x00000002, or to 0x1000 -> no rom_en, and fault=1 from cycle N+1.
REQ-037 rst_n asserted mid-stream -> all outputs zero asynchronously; after release, fetching restarts at RESET_PC.
